// File: rtl/uart_tx.sv
// uart_tx: 8N1 serial transmitter with a runtime baud divisor.
//   clk_i   - system clock, rising edge
//   rst_i   - asynchronous active-high reset
//   start_i - transmit request, sampled only in IDLE
//   data_i  - byte to send, latched with start_i
//   vmax_i  - bit period in clk_i cycles, latched with start_i (values below 2 act as 2)
//   tx_o    - serial line, idles high
//   busy_o  - high while a frame is in progress
//   done_o  - one-cycle pulse at frame completion
module uart_tx #(
    parameter int Width = 10
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [7:0]       data_i,
    input  logic [Width-1:0] vmax_i,
    output logic             tx_o,
    output logic             busy_o,
    output logic             done_o
);
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
    state_t state, state_n;
    logic [Width-1:0] cnt, per;
    logic [2:0] idx;
    logic [7:0] sh, sh_n;
    logic tc, accept, tx_n, busy_n, done_n;
    assign tc = cnt == per - Width'(1);
    assign accept = state == IDLE && start_i;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  state_n = start_i ? START : IDLE;
            START: state_n = tc ? DATA : START;
            DATA:  state_n = tc && idx == 3'd7 ? STOP : DATA;
            STOP:  state_n = tc ? IDLE : STOP;
            default: state_n = IDLE;
        endcase
    end
    // Outputs are derived from the next state so they can be registered
    // and still line up with the state they describe.
    always_comb begin
        sh_n = accept ? data_i : state == DATA && tc ? {1'b0, sh[7:1]} : sh;
        tx_n = state_n == START ? 1'b0 : state_n == DATA ? sh_n[0] : 1'b1;
        busy_n = state_n != IDLE;
        done_n = state == STOP && tc;
    end
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            cnt <= '0;
            per <= '0;
            idx <= '0;
            sh <= '0;
            tx_o <= 1'b1;
            busy_o <= 1'b0;
            done_o <= 1'b0;
        end else begin
            cnt <= state == IDLE || tc ? '0 : cnt + Width'(1);
            if (accept) per <= vmax_i < Width'(2) ? Width'(2) : vmax_i;
            // The index wraps from 7 back to 0 as DATA ends, ready for the next frame.
            if (state == DATA && tc) idx <= idx + 3'd1;
            sh <= sh_n;
            tx_o <= tx_n;
            busy_o <= busy_n;
            done_o <= done_n;
        end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed self-checking bench for uart_tx.
module tb_uart_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic [7:0] data = 8'h00;
    logic [9:0] vmax = 10'd0;
    logic tx, busy, done;
    int tests = 0;
    int fails = 0;

    uart_tx #(.Width(10)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .data_i(data),
        .vmax_i(vmax),
        .tx_o(tx),
        .busy_o(busy),
        .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; requests a frame and checks every cycle of it.
    // hold keeps start high for back-to-back, g >= 1 pulses an ignored request at sample g.
    task automatic send(input string tag, input logic [7:0] d, input logic [9:0] v,
                        input int p, input bit hold, input int g);
        int be[10];
        int ctl;
        logic e;
        foreach (be[b]) be[b] = 0;
        ctl = 0;
        start = 1'b1;
        data = d;
        vmax = v;
        for (int i = 0; i < 10 * p; i++) begin
            @(negedge clk);
            if (i == 0 && !hold) start = 1'b0;
            if (i == g) begin
                start = 1'b1;
                data = 8'hFF;
                vmax = 10'd3;
            end
            if (i == g + 1) start = 1'b0;
            e = i / p == 0 ? 1'b0 : i / p == 9 ? 1'b1 : d[i / p - 1];
            if (tx !== e) be[i / p]++;
            if (busy !== 1'b1 || done !== 1'b0) ctl++;
        end
        for (int b = 0; b < 10; b++) check($sformatf("%s bit%0d bad cycles", tag, b), be[b], 0);
        check($sformatf("%s busy/done during frame", tag), ctl, 0);
        @(negedge clk);
        check($sformatf("%s end busy,done,tx", tag), {busy, done, tx}, 3'b011);
        if (!hold) begin
            @(negedge clk);
            check($sformatf("%s after end busy,done,tx", tag), {busy, done, tx}, 3'b001);
        end
    endtask

    initial begin
        int bad;
        #3 rst = 1'b1;
        #1 check("async reset tx,busy,done", {tx, busy, done}, 3'b100);
        @(negedge clk) rst = 1'b0;
        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) bad++;
        end
        check("idle 100 cycles", bad, 0);

        send("A5 p5 ignored req", 8'hA5, 10'd5, 5, 1'b0, 12);
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no second frame", bad, 0);

        send("b2b 00", 8'h00, 10'd4, 4, 1'b1, -1);
        send("b2b FF", 8'hFF, 10'd4, 4, 1'b0, -1);

        start = 1'b1;
        data = 8'h35;
        vmax = 10'd5;
        @(negedge clk) start = 1'b0;
        repeat (21) @(negedge clk);
        check("data bit3 before reset", {tx, busy}, 2'b01);
        #2 rst = 1'b1;
        #1 check("mid-frame reset tx,busy,done", {tx, busy, done}, 3'b100);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        send("after reset 35", 8'h35, 10'd5, 5, 1'b0, -1);

        send("3C p0", 8'h3C, 10'd0, 2, 1'b0, -1);
        send("3C p1", 8'h3C, 10'd1, 2, 1'b0, -1);
        send("96 p868", 8'h96, 10'd868, 868, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
